l2_request_arbiter: RTL and testbench
=====================================

# l2_request_arbiter

Round-robin arbiter that shares one core's single L2 request port among three L1-side requesters: instruction-cache miss queue (port 0), data-cache miss queue (port 1) and store buffer (port 2). It registers the granted request onto the pci_* bus, holds it stable until the L2 acknowledges, and returns a one-cycle acknowledge to the owning requester. It sits between the L1 units and the L2 cache; the cpi_* response path does not pass through it.

## Interface
Parameters:
- UNIT_ID0, default 0: pci_unit value driven when port 0 is granted.
- UNIT_ID1, default 1: pci_unit value for port 1.
- UNIT_ID2, default 2: pci_unit value for port 2.

Ports (packed vectors; field N occupies slice [N*W +: W]):
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  3  bit N: requester N has a request pending.
- req_strand  input  6  2 bits per requester.
- req_op  input  9  3 bits per requester.
- req_way  input  6  2 bits per requester.
- req_address  input  78  26 bits per requester (line address).
- req_data  input  1536  512 bits per requester.
- req_mask  input  192  64 bits per requester.
- req_ack  output  3  bit N pulses one cycle when requester N's request is accepted by L2.
- pci_valid  output  1  request valid to L2.
- pci_ack  input  1  L2 accepts current request.
- pci_unit  output  2  UNIT_IDn of granted port.
- pci_strand, pci_op, pci_way, pci_address, pci_data, pci_mask  outputs  2, 3, 2, 26, 512, 64  registered payload of granted port.

## Operation
- Requester contract: once req_valid[N] is high, its payload stays constant and valid stays high until the cycle req_ack[N] is high; the requester may present a new request (or drop valid) the following cycle.
- State machine: IDLE, BUSY.
  - IDLE: if any req_valid bit set, pick winner by round-robin, latch its payload and UNIT_IDn into pci_* registers, record grant index, go BUSY. Otherwise stay IDLE.
  - BUSY: pci_valid=1. When pci_ack=1: req_ack[grant]=1 (combinational from pci_ack and grant), advance last_grant to grant, go IDLE. Otherwise hold all pci_* unchanged.
- Round-robin: search order starts at (last_grant+1) mod 3, wraps; first set req_valid bit wins. last_grant updates only on acknowledged grant.
- req_ack bits other than grant are 0; req_ack is 0 in IDLE regardless of pci_ack.
- pci_ack in IDLE is a protocol error: ignored, flagged by an assertion.
- req_valid[grant] dropping while BUSY is a requester error: arbiter keeps presenting latched request until acked.

## Timing
- Reset (async, immediate): state=IDLE, pci_valid=0, all pci_* payload=0, pci_unit=0, req_ack=0, last_grant=2 (port 0 wins first).
- Reset asserted mid-transaction aborts it; no req_ack is issued; requesters are reset by the same signal.
- Latency: req_valid rising in cycle T (arbiter IDLE) -> pci_valid=1 in cycle T+1.
- pci_ack in cycle T -> req_ack in cycle T, pci_valid=0 in T+1 (IDLE), next grant visible T+2.
- Minimum issue interval: 2 cycles per request with pci_ack held high.
- Arbitration samples req_valid only in IDLE; requests arriving while BUSY wait.
- Starvation bound: a continuously valid requester is granted within 3 grants.

## Test plan
- Single request: reset, req_valid=3'b010 with address 26'h12345, strand 1, op 3'd1 -> cycle+1 pci_valid=1, pci_unit=1, pci_address=26'h12345; pci_ack one cycle -> req_ack=3'b010 that cycle, pci_valid=0 next.
- Reset priority: after reset, req_valid=3'b111, pci_ack always 1 -> grant order 0,1,2,0,1,2; req_ack sequence 001,010,100,001 each 2 cycles apart.
- Hold under backpressure: grant port 2, pci_ack low 10 cycles -> pci_valid and all payload (incl. 512-bit data, 64-bit mask) unchanged, req_ack=0; ack on cycle 11 -> req_ack=3'b100.
- Fairness with late arrival: port 0 streaming, port 2 raises valid while port 0 BUSY -> next grant after port 0 ack is port 2, not port 0.
- Async reset mid-BUSY: reset_n low between clock edges while pci_valid=1 -> pci_valid=0 immediately, no req_ack; after release, first grant goes to lowest valid port starting at 0.
- Spurious ack: pci_ack=1 while IDLE -> req_ack=0, state stays IDLE, assertion fires.

Source files
------------

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing one L2 request port among I$, D$ and store buffer.
// Registers the granted request on pci_* and holds it until the L2 acknowledges.
module l2_request_arbiter #(
  parameter logic [1:0] UNIT_ID0 = 2'd0,
  parameter logic [1:0] UNIT_ID1 = 2'd1,
  parameter logic [1:0] UNIT_ID2 = 2'd2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    req_valid,
  input  logic [5:0]    req_strand,
  input  logic [8:0]    req_op,
  input  logic [5:0]    req_way,
  input  logic [77:0]   req_address,
  input  logic [1535:0] req_data,
  input  logic [191:0]  req_mask,
  output logic [2:0]    req_ack,
  output logic          pci_valid,
  input  logic          pci_ack,
  output logic [1:0]    pci_unit,
  output logic [1:0]    pci_strand,
  output logic [2:0]    pci_op,
  output logic [1:0]    pci_way,
  output logic [25:0]   pci_address,
  output logic [511:0]  pci_data,
  output logic [63:0]   pci_mask
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [1:0] grant;
  logic [1:0] last_grant;

  logic [1:0]   strand_a [3];
  logic [2:0]   op_a     [3];
  logic [1:0]   way_a    [3];
  logic [25:0]  addr_a   [3];
  logic [511:0] data_a   [3];
  logic [63:0]  mask_a   [3];

  for (genvar n = 0; n < 3; n++) begin : g_split
    assign strand_a[n] = req_strand[n*2 +: 2];
    assign op_a[n]     = req_op[n*3 +: 3];
    assign way_a[n]    = req_way[n*2 +: 2];
    assign addr_a[n]   = req_address[n*26 +: 26];
    assign data_a[n]   = req_data[n*512 +: 512];
    assign mask_a[n]   = req_mask[n*64 +: 64];
  end

  function automatic logic [1:0] inc3(logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search starts one past the last acknowledged owner and wraps.
  logic [1:0] p0, p1, p2, pick;
  logic [1:0] pick_unit;

  always_comb begin
    p0 = inc3(last_grant);
    p1 = inc3(p0);
    p2 = inc3(p1);
    if (req_valid[p0])      pick = p0;
    else if (req_valid[p1]) pick = p1;
    else                    pick = p2;
  end

  always_comb begin
    pick_unit = UNIT_ID2;
    unique case (1'b1)
      (pick == 2'd0): pick_unit = UNIT_ID0;
      (pick == 2'd1): pick_unit = UNIT_ID1;
      default:        pick_unit = UNIT_ID2;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= 2'd0;
      last_grant  <= 2'd2;
      pci_unit    <= '0;
      pci_strand  <= '0;
      pci_op      <= '0;
      pci_way     <= '0;
      pci_address <= '0;
      pci_data    <= '0;
      pci_mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state       <= BUSY;
            grant       <= pick;
            pci_unit    <= pick_unit;
            pci_strand  <= strand_a[pick];
            pci_op      <= op_a[pick];
            pci_way     <= way_a[pick];
            pci_address <= addr_a[pick];
            pci_data    <= data_a[pick];
            pci_mask    <= mask_a[pick];
          end
        end
        BUSY: begin
          if (pci_ack) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pci_valid = (state == BUSY);

  always_comb begin
    req_ack = 3'b000;
    if (state == BUSY && pci_ack) req_ack[grant] = 1'b1;
  end

  a_no_idle_ack: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(state == IDLE && pci_ack)
  );

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: directed scenarios plus random
// requesters checked against a transaction-level round-robin model.
module tb_l2_request_arbiter;

  logic          clk;
  logic          reset_n;
  logic [2:0]    rv;
  logic          ack_in;
  logic [1:0]    strand [3];
  logic [2:0]    op     [3];
  logic [1:0]    way    [3];
  logic [25:0]   addr   [3];
  logic [511:0]  dat    [3];
  logic [63:0]   msk    [3];

  logic [5:0]    req_strand;
  logic [8:0]    req_op;
  logic [5:0]    req_way;
  logic [77:0]   req_address;
  logic [1535:0] req_data;
  logic [191:0]  req_mask;
  logic [2:0]    req_ack;
  logic          pci_valid;
  logic [1:0]    pci_unit;
  logic [1:0]    pci_strand;
  logic [2:0]    pci_op;
  logic [1:0]    pci_way;
  logic [25:0]   pci_address;
  logic [511:0]  pci_data;
  logic [63:0]   pci_mask;

  assign req_strand  = {strand[2], strand[1], strand[0]};
  assign req_op      = {op[2], op[1], op[0]};
  assign req_way     = {way[2], way[1], way[0]};
  assign req_address = {addr[2], addr[1], addr[0]};
  assign req_data    = {dat[2], dat[1], dat[0]};
  assign req_mask    = {msk[2], msk[1], msk[0]};

  l2_request_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (rv),
    .req_strand  (req_strand),
    .req_op      (req_op),
    .req_way     (req_way),
    .req_address (req_address),
    .req_data    (req_data),
    .req_mask    (req_mask),
    .req_ack     (req_ack),
    .pci_valid   (pci_valid),
    .pci_ack     (ack_in),
    .pci_unit    (pci_unit),
    .pci_strand  (pci_strand),
    .pci_op      (pci_op),
    .pci_way     (pci_way),
    .pci_address (pci_address),
    .pci_data    (pci_data),
    .pci_mask    (pci_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: who owns the port, who was last served, what was latched.
  bit           m_busy;
  int           m_owner;
  int           m_last;
  int           m_acked;
  logic [1:0]   m_unit;
  logic [1:0]   m_strand;
  logic [2:0]   m_op;
  logic [1:0]   m_way;
  logic [25:0]  m_addr;
  logic [511:0] m_data;
  logic [63:0]  m_mask;

  task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= 3; k++) begin
      int p = (m_last + k) % 3;
      if (rv[p]) return p;
    end
    return 0;
  endfunction

  task automatic new_req(int n);
    addr[n]   = 26'($urandom);
    strand[n] = 2'($urandom);
    op[n]     = 3'($urandom);
    way[n]    = 2'($urandom);
    msk[n]    = {$urandom, $urandom};
    for (int i = 0; i < 16; i++) dat[n][i*32 +: 32] = $urandom;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 2; m_acked = -1;
    m_unit = '0; m_strand = '0; m_op = '0; m_way = '0;
    m_addr = '0; m_data = '0; m_mask = '0;
  endtask

  task automatic chk_outputs();
    chk("pci_valid",   512'(pci_valid),   512'(m_busy));
    chk("pci_unit",    512'(pci_unit),    512'(m_unit));
    chk("pci_strand",  512'(pci_strand),  512'(m_strand));
    chk("pci_op",      512'(pci_op),      512'(m_op));
    chk("pci_way",     512'(pci_way),     512'(m_way));
    chk("pci_address", 512'(pci_address), 512'(m_addr));
    chk("pci_data",    pci_data,          m_data);
    chk("pci_mask",    512'(pci_mask),    512'(m_mask));
  endtask

  // Called at a negedge with inputs already driven for this cycle.
  task automatic tick();
    logic [2:0] exp_ack;
    int w;
    exp_ack = 3'b000;
    if (m_busy && ack_in) exp_ack[m_owner] = 1'b1;
    #1 chk("req_ack", 512'(req_ack), 512'(exp_ack));
    m_acked = -1;
    if (!m_busy) begin
      if (rv != 3'b000) begin
        w = rr_pick();
        m_busy = 1; m_owner = w; m_unit = 2'(w);
        m_strand = strand[w]; m_op = op[w]; m_way = way[w];
        m_addr = addr[w]; m_data = dat[w]; m_mask = msk[w];
      end
    end else if (ack_in) begin
      m_last = m_owner; m_busy = 0; m_acked = m_owner;
    end
    @(posedge clk);
    #1 chk_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rv = 3'b000; ack_in = 1'b0;
    model_reset();
    #1;
    chk("rst_req_ack", 512'(req_ack), 512'(0));
    chk_outputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; rv = 3'b000; ack_in = 1'b0;
    for (int n = 0; n < 3; n++) begin
      strand[n] = '0; op[n] = '0; way[n] = '0;
      addr[n] = '0; dat[n] = '0; msk[n] = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request on port 1
    new_req(1);
    addr[1] = 26'h12345; strand[1] = 2'd1; op[1] = 3'd1;
    rv = 3'b010;
    tick();
    chk("single_unit", 512'(pci_unit), 512'(1));
    chk("single_addr", 512'(pci_address), 512'(26'h12345));
    ack_in = 1'b1;
    #1 chk("single_ack", 512'(req_ack), 512'(3'b010));
    tick();
    rv = 3'b000; ack_in = 1'b0;
    chk("single_drop", 512'(pci_valid), 512'(0));
    tick();

    // Rotating priority with ack held whenever a request is presented
    do_reset();
    for (int n = 0; n < 3; n++) new_req(n);
    rv = 3'b111;
    for (int g = 0; g < 6; g++) begin
      ack_in = 1'b0;
      tick();
      chk("rr_order", 512'(pci_unit), 512'(g % 3));
      ack_in = 1'b1;
      tick();
      new_req(m_acked);
    end
    ack_in = 1'b0; rv = 3'b000;
    tick();

    // Backpressure: port 2 held for 10 cycles
    new_req(2);
    rv = 3'b100;
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("bp_data", pci_data, dat[2]);
    ack_in = 1'b1;
    #1 chk("bp_ack", 512'(req_ack), 512'(3'b100));
    tick();
    ack_in = 1'b0; rv = 3'b000;
    tick();

    // Late arrival on port 2 wins over streaming port 0
    do_reset();
    new_req(0);
    rv = 3'b001;
    tick();
    new_req(2);
    rv = 3'b101; ack_in = 1'b1;
    tick();
    new_req(0);
    ack_in = 1'b0;
    tick();
    chk("fair_unit", 512'(pci_unit), 512'(2));
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0; rv = 3'b000;
    tick();

    // Asynchronous reset while busy
    new_req(1);
    rv = 3'b010;
    tick();
    chk("pre_rst_valid", 512'(pci_valid), 512'(1));
    #2 reset_n = 1'b0; ack_in = 1'b1;
    #1 chk("arst_valid", 512'(pci_valid), 512'(0));
    chk("arst_ack", 512'(req_ack), 512'(0));
    ack_in = 1'b0; rv = 3'b000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    new_req(1); new_req(2);
    rv = 3'b110;
    tick();
    chk("arst_first", 512'(pci_unit), 512'(1));
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0; rv = 3'b000;
    tick();

    // Random requesters obeying the hold-until-ack contract
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 3; n++) begin
        if (m_acked == n) begin
          if ($urandom_range(3) == 0) rv[n] = 1'b0;
          else new_req(n);
        end else if (!rv[n] && $urandom_range(3) == 0) begin
          new_req(n);
          rv[n] = 1'b1;
        end
      end
      ack_in = m_busy && ($urandom_range(1) == 1);
      tick();
    end
    ack_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
